// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined add/subtract unit.
//   OP_ADD / OP_SUB : encodings of the 'sub' operand-select bit
//   slice_width()   : bits handled by each pipeline stage
//   sign_t          : operand sign bits carried into the final stage, used to
//                     form the signed-overflow flag and the saturation limit
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic a_msb;
        logic b_msb;
    } sign_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Operand and result handshake bundle of the pipelined add/subtract unit.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, result, cout, overflow
// modport master : operand source / result consumer (drives operands, out_ready)
// modport slave  : the adder itself (drives in_ready and the result fields)
// -----------------------------------------------------------------------------
interface pipelined_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, overflow
    );

endinterface

// File: rtl/adder_slice.sv
// -----------------------------------------------------------------------------
// adder_slice
// One registered SW-bit slice of the carry chain.
//   clk, rst : clock, synchronous active-high reset (clears sum and carry)
//   en       : hold enable; the registers keep their value when low
//   a, b     : slice operands (b already inverted for subtraction)
//   cin      : carry into the slice (registered carry of the previous slice)
//   sum      : registered slice sum
//   cout     : registered carry out of the slice
// -----------------------------------------------------------------------------
module adder_slice #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout
);

    logic [SW:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (en) begin
            sum  <= total[SW-1:0];
            cout <= total[SW];
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// Pipelined WIDTH-bit add/subtract unit. The carry chain is cut into STAGES
// registered slices of WIDTH/STAGES bits; result, carry-out and signed
// overflow appear STAGES cycles after the operand handshake. One op per cycle.
//   clk, rst  : clock, synchronous active-high reset (drops all in-flight ops)
//   bus       : pipelined_adder_if.slave
//               in_valid/in_ready + a, b, cin, sub   operand handshake
//               out_valid/out_ready + result, cout, overflow   result handshake
// Parameters: WIDTH (operand width), STAGES (1..WIDTH, must divide WIDTH).
// Build option: define SATURATE_EN to clamp the result to the signed limit
// whenever overflow is flagged (raw modulo result otherwise).
// Backpressure freezes the whole pipe, bubbles included, so in_ready is simply
// the inverse of a stalled output.
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_adder_if.slave  bus
);

    localparam int SW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: STAGES must be 1..WIDTH and divide WIDTH");
    end

    logic             stall;
    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Subtraction as a + ~b + ~borrow, so cout=1 means "no borrow".
    assign b_eff = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    assign c0    = (bus.sub == OP_SUB) ? ~bus.cin : bus.cin;

    assign stall        = bus.out_valid && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = en;

    // Stage gi consumes the lowest slice of the operands it receives, forwards
    // the untouched upper slices and holds the finished lower result bits.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int SRC_W = WIDTH - gi * SW;

        logic [SRC_W-1:0]       a_src;
        logic [SRC_W-1:0]       b_src;
        logic                   c_src;
        logic                   v_src;
        logic [SW-1:0]          sum;
        logic                   carry;
        logic                   valid_reg;
        logic [(gi+1)*SW-1:0]   res_all;

        if (gi == 0) begin : g_head
            assign a_src   = bus.a;
            assign b_src   = b_eff;
            assign c_src   = c0;
            assign v_src   = bus.in_valid;
            assign res_all = sum;
        end else begin : g_body
            logic [gi*SW-1:0] res_done_reg;

            assign a_src = g_stage[gi-1].g_fwd.a_rem_reg;
            assign b_src = g_stage[gi-1].g_fwd.b_rem_reg;
            assign c_src = g_stage[gi-1].carry;
            assign v_src = g_stage[gi-1].valid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    res_done_reg <= '0;
                end else if (en) begin
                    res_done_reg <= g_stage[gi-1].res_all;
                end
            end

            assign res_all = {sum, res_done_reg};
        end

        adder_slice #(
            .SW (SW)
        ) u_slice (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .a    (a_src[SW-1:0]),
            .b    (b_src[SW-1:0]),
            .cin  (c_src),
            .sum  (sum),
            .cout (carry)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
            end else if (en) begin
                valid_reg <= v_src;
            end
        end

        if (gi < LAST) begin : g_fwd
            logic [SRC_W-SW-1:0] a_rem_reg;
            logic [SRC_W-SW-1:0] b_rem_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_rem_reg <= '0;
                    b_rem_reg <= '0;
                end else if (en) begin
                    a_rem_reg <= a_src[SRC_W-1:SW];
                    b_rem_reg <= b_src[SRC_W-1:SW];
                end
            end
        end
    end

    // The last stage sees the operand MSBs; capture them alongside its slice.
    sign_t            sign_reg;
    logic [WIDTH-1:0] raw;
    logic             ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg <= '0;
        end else if (en) begin
            sign_reg.a_msb <= g_stage[LAST].a_src[SW-1];
            sign_reg.b_msb <= g_stage[LAST].b_src[SW-1];
        end
    end

    assign raw = g_stage[LAST].res_all;
    assign ovf = (sign_reg.a_msb == sign_reg.b_msb) && (raw[WIDTH-1] != sign_reg.a_msb);

    assign bus.out_valid = g_stage[LAST].valid_reg;
    assign bus.cout      = g_stage[LAST].carry;
    assign bus.overflow  = ovf;

`ifdef SATURATE_EN
    // Clamp toward the sign of a: positive overflow -> 0x7F..F, negative -> 0x80..0.
    assign bus.result = !ovf           ? raw :
                        sign_reg.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} :
                                         {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign bus.result = raw;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Self-checking bench: a WIDTH=8/STAGES=2 instance driven by a vector table and
// hand-written latency, stall and reset sequences, plus WIDTH=16/STAGES=4 and
// WIDTH=8/STAGES=1 instances under random operands and random backpressure.
// Expected results are queued at the operand handshake and popped at the
// result handshake.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam int NOPS = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_r = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_done [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Reference: {cout, overflow, result} for a w-bit add/sub.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin,
                                              input logic sub);
        logic [31:0] mask;
        logic [31:0] be;
        logic [31:0] res;
        logic [32:0] full;
        logic        c0;
        logic        cout;
        logic        am;
        logic        bm;
        logic        ovf;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        be   = sub ? (~b & mask) : b;
        c0   = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, be} + {32'h0, c0};
        cout = full[w];
        res  = full[31:0] & mask;
        am   = a[w-1];
        bm   = be[w-1];
        ovf  = (am == bm) && (res[w-1] != am);
        if (SAT && ovf) res = am ? (32'h1 << (w - 1)) : (mask >> 1);
        return {cout, ovf, res};
    endfunction

    // ------------------------------------------------------------------ DUT 0
    pipelined_adder_if #(.WIDTH(8)) bus0 ();

    pipelined_adder #(
        .WIDTH  (8),
        .STAGES (2)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    logic [33:0] exp_q0 [$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] res;
        logic [7:0] sat_res;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [33:0] pack8(input logic [7:0] res, input logic cout, input logic ovf);
        return {cout, ovf, 24'h0, res};
    endfunction

    // Result-side monitor for DUT 0.
    logic        prev_stall0 = 1'b0;
    logic [34:0] prev_out0   = '0;
    initial begin : mon0
        logic [34:0] cur;
        forever begin
            @(negedge clk);
            cur = {bus0.out_valid, bus0.cout, bus0.overflow, 24'h0, bus0.result};
            if (rst) begin
                prev_stall0 = 1'b0;
            end else begin
                if (prev_stall0) check("stall_hold", 64'(cur), 64'(prev_out0));
                if (bus0.out_valid && bus0.out_ready) begin
                    if (exp_q0.size() == 0)
                        fail_now("unexpected_out", $sformatf("got result %h, required no output", bus0.result));
                    else
                        check("out_data", 64'(cur[33:0]), 64'(exp_q0.pop_front()));
                end
                prev_stall0 = bus0.out_valid && !bus0.out_ready;
                prev_out0   = cur;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [33:0] exp);
        bus0.a        = a;
        bus0.b        = b;
        bus0.cin      = cin;
        bus0.sub      = sub;
        bus0.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                exp_q0.push_back(exp);
                @(posedge clk);
                #1;
                bus0.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        bus0.in_valid = 1'b0;
        fail_now("send_timeout", "in_ready stayed 0 for 100 cycles, required 1");
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 20 && exp_q0.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check(name, 64'(exp_q0.size()), 64'd0);
    endtask

    initial begin : main
        logic [7:0] sa;
        logic [7:0] sb;
        bus0.in_valid  = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.cin       = 1'b0;
        bus0.sub       = 1'b0;
        bus0.out_ready = 1'b1;

        //            a      b      cin   sub   res    sat    cout  ovf
        tbl[0]  = '{8'h05, 8'h06, 1'b0, 1'b0, 8'h0B, 8'h0B, 1'b0, 1'b0};
        tbl[1]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 8'hFE, 1'b1, 1'b0};
        tbl[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        tbl[3]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
        tbl[4]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        tbl[5]  = '{8'h05, 8'h06, 1'b1, 1'b0, 8'h0C, 8'h0C, 1'b0, 1'b0};
        tbl[6]  = '{8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 8'h0A, 1'b1, 1'b0};
        tbl[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        tbl[8]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 8'h7F, 1'b0, 1'b1};
        tbl[11] = '{8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("rst_result",    64'(bus0.result),    64'd0);
        check("rst_cout",      64'(bus0.cout),      64'd0);
        check("rst_overflow",  64'(bus0.overflow),  64'd0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rst_r = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus0.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Latency: two register stages between handshake and out_valid.
        bus0.a = 8'h05; bus0.b = 8'h06; bus0.cin = 1'b0; bus0.sub = 1'b0;
        bus0.in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", 64'(bus0.in_ready), 64'd1);
        exp_q0.push_back(pack8(8'h0B, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        @(negedge clk);
        check("lat_early", 64'(bus0.out_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_due",    64'(bus0.out_valid), 64'd1);
        check("lat_result", 64'(bus0.result),    64'h0B);
        @(posedge clk);
        #1;

        // Table vectors, back to back.
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                 pack8(SAT ? tbl[i].sat_res : tbl[i].res, tbl[i].cout, tbl[i].ovf));
        end
        drain("table_drain");

        // Five ops streamed with a 3-cycle output stall in the middle.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    sa = 8'h11 * 8'(i + 1);
                    sb = 8'h23 + 8'h31 * 8'(i);
                    send(sa, sb, 1'(i), 1'(i >> 1), ref_model(8, 32'(sa), 32'(sb), 1'(i), 1'(i >> 1)));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus0.out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_out_valid", 64'(bus0.out_valid), 64'd1);
                    check("stall_in_ready",  64'(bus0.in_ready),  64'd0);
                    @(posedge clk);
                    #1;
                end
                bus0.out_ready = 1'b1;
            end
        join
        drain("stall_drain");

        // Reset with two ops in flight: neither may ever emerge.
        send(8'h21, 8'h12, 1'b0, 1'b0, pack8(8'h33, 1'b0, 1'b0));
        bus0.out_ready = 1'b0;
        send(8'h44, 8'h11, 1'b0, 1'b1, pack8(8'h33, 1'b1, 1'b0));
        rst = 1'b1;
        exp_q0.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        check("midrst_result",    64'(bus0.result),    64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(bus0.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(8'h05, 8'h06, 1'b0, 1'b0, pack8(8'h0B, 1'b0, 1'b0));
        drain("post_rst_drain");

        // Wait for the random runs.
        for (int t = 0; t < 50000 && !(rand_done[0] && rand_done[1]); t++) @(posedge clk);
        if (!(rand_done[0] && rand_done[1]))
            fail_now("rand_timeout", "random runs did not complete within 50000 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ------------------------------------------------------- random instances
    for (genvar gi = 0; gi < 2; gi++) begin : g_rand
        localparam int RW = (gi == 0) ? 16 : 8;
        localparam int RS = (gi == 0) ? 4 : 1;

        pipelined_adder_if #(.WIDTH(RW)) rbus ();

        pipelined_adder #(
            .WIDTH  (RW),
            .STAGES (RS)
        ) rdut (
            .clk (clk),
            .rst (rst_r),
            .bus (rbus)
        );

        logic [33:0] rq [$];

        function automatic logic [RW-1:0] pick();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return {1'b1, {(RW-1){1'b0}}};
                3:       return {1'b0, {(RW-1){1'b1}}};
                default: return RW'($urandom);
            endcase
        endfunction

        initial begin : rand_run
            string       nm;
            int          accepted;
            logic        taken;
            logic        prev_stall;
            logic [34:0] prev_out;
            logic [34:0] cur;
            nm         = (gi == 0) ? "r16s4" : "r8s1";
            accepted   = 0;
            taken      = 1'b1;
            prev_stall = 1'b0;
            prev_out   = '0;
            rbus.in_valid  = 1'b0;
            rbus.a         = '0;
            rbus.b         = '0;
            rbus.cin       = 1'b0;
            rbus.sub       = 1'b0;
            rbus.out_ready = 1'b1;
            for (int t = 0; t < 20 && rst_r; t++) @(posedge clk);
            #1;
            for (int cyc = 0; cyc < 40000 && (accepted < NOPS || rq.size() != 0); cyc++) begin
                if (accepted < NOPS) begin
                    if (taken) begin
                        rbus.in_valid = ($urandom_range(0, 3) != 0);
                        rbus.a        = pick();
                        rbus.b        = pick();
                        rbus.cin      = 1'($urandom);
                        rbus.sub      = 1'($urandom);
                    end
                    rbus.out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    rbus.in_valid  = 1'b0;
                    rbus.out_ready = 1'b1;
                end
                @(negedge clk);
                cur = {rbus.out_valid, rbus.cout, rbus.overflow, 32'(rbus.result)};
                if (prev_stall) check({nm, "_hold"}, 64'(cur), 64'(prev_out));
                if (rbus.out_valid && rbus.out_ready) begin
                    if (rq.size() == 0)
                        fail_now({nm, "_unexpected_out"}, $sformatf("got result %h, required no output", rbus.result));
                    else
                        check({nm, "_out"}, 64'(cur[33:0]), 64'(rq.pop_front()));
                end
                if (rbus.in_valid && rbus.in_ready) begin
                    rq.push_back(ref_model(RW, 32'(rbus.a), 32'(rbus.b), rbus.cin, rbus.sub));
                    accepted++;
                    taken = 1'b1;
                end else begin
                    taken = !rbus.in_valid;
                end
                prev_stall = rbus.out_valid && !rbus.out_ready;
                prev_out   = cur;
                @(posedge clk);
                #1;
            end
            check({nm, "_accepted"}, 64'(accepted), 64'(NOPS));
            check({nm, "_drain"}, 64'(rq.size()), 64'd0);
            rand_done[gi] = 1'b1;
        end
    end

endmodule
